param_seq_det: RTL and testbench
================================

# param_seq_det

Parametrised serial sequence detector with a runtime-programmable pattern, programmable pattern length up to MAX_LEN bits, and selectable overlapping/non-overlapping detection. Each detection produces a clean registered one-cycle pulse. The block sits directly on a one-bit serial input stream, qualified by a valid strobe. It is the general replacement for the fixed-pattern, fixed-mode sequence detectors in the sequential-circuits library.

## Interface
- MAX_LEN, 8, maximum pattern length in bits (2..32).
- LEN_W, $clog2(MAX_LEN+1), width of pat_len.
- CNT_W, 16, width of match_cnt (only used with SEQ_DET_CNT_EN).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- clr  in  1  synchronous clear of history/fill state (and counter); higher priority than in_valid.
- in_valid  in  1  serin is sampled only when high.
- serin  in  1  serial data bit.
- pattern  in  MAX_LEN  target pattern; pattern[pat_len-1] is first bit received, pattern[0] last.
- pat_len  in  LEN_W  active pattern length, legal 1..MAX_LEN.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- det_out  out  1  registered one-cycle detection pulse.
- fill  out  LEN_W  number of valid history bits, saturates at MAX_LEN.
- len_err  out  1  registered flag: pat_len is 0 or > MAX_LEN.
- match_cnt  out  CNT_W  saturating detection count (SEQ_DET_CNT_EN only).

## Operation
- State: history shift register hist[MAX_LEN-1:0] and fill counter fill.
- On a clock edge with in_valid=1 and clr=0:
  - hist_n = {hist[MAX_LEN-2:0], serin}.
  - fill_n = min(fill+1, MAX_LEN).
- Match condition: len legal, fill_n >= pat_len, and hist_n[pat_len-1:0] == pattern[pat_len-1:0]. Unused upper pattern bits are ignored.
- On a match:
  - det_out <= 1.
  - overlap=0: fill <= 0, so the matched bits cannot contribute to a later match. hist is still updated.
  - overlap=1: fill <= fill_n.
- If there is no match, or in_valid=0, det_out <= 0.
- in_valid=0: hist and fill hold their values.
- clr=1: fill <= 0, det_out <= 0, match_cnt <= 0. hist contents are don't-care.
- pattern, pat_len and overlap are sampled on every valid edge.
  - Changing them mid-stream takes effect on the next valid bit, evaluated against the existing history.
  - Software must assert clr if stale history is unwanted.
- Illegal pat_len (0 or > MAX_LEN):
  - No detection ever fires.
  - len_err = 1, registered one cycle after pat_len is applied.
  - History keeps shifting.

## Timing
- Reset values: det_out=0, fill=0, len_err=0, match_cnt=0, hist=0.
- Latency: det_out is high for exactly the one cycle following the edge that samples the last pattern bit.
- Back-to-back valid bits are supported at full rate; no stall or ready signal exists.
- Overlapping mode: consecutive detections may produce det_out on consecutive cycles (e.g. pattern "11", input "111" gives two pulses).
- Non-overlapping mode: the minimum spacing between pulses is pat_len valid bits.
- Reset asserted mid-stream immediately forces all outputs to their reset values, independent of clk. The first bit sampled after deassertion starts a fresh history.
- clr and in_valid on the same edge: clr wins and the bit is discarded.

## Configuration
- SEQ_DET_CNT_EN defined:
  - match_cnt is present.
  - It increments on every detection, saturates at 2^CNT_W-1, and is cleared by rst and clr.
- SEQ_DET_CNT_EN undefined:
  - The counter logic is removed.
  - match_cnt is tied to 0.
  - All other behaviour is identical.

## Test plan
- Reset/idle: assert rst mid-stream with fill=5 -> det_out=0, fill=0 and len_err=0 immediately; no pulse for the next 3 bits.
- Non-overlap, pattern=3'b101, pat_len=3, overlap=0, input 1,0,1,0,1 -> exactly one det_out pulse, in the cycle after the 3rd bit; fill=2 after the 5th bit.
- Overlap, same pattern, overlap=1, input 1,0,1,0,1 -> two pulses, after bit 3 and bit 5.
- Full length and gaps: MAX_LEN=8, pattern=8'hA5, pat_len=8, bits 1,0,1,0,0,1,0,1 with in_valid low for 2 cycles between bits 4 and 5 -> one pulse after bit 8; fill saturates at 8.
- Illegal length and clr: pat_len=0 -> len_err=1 next cycle and no pulses on any input. Then set pat_len=2, pattern=2'b11 and assert clr together with in_valid and serin=1 -> that bit is ignored; the next two 1s give one pulse.
- Counter (SEQ_DET_CNT_EN, CNT_W=2): five detections in overlap mode -> match_cnt reads 1,2,3,3,3; clr -> 0.

Source files
------------

// File: rtl/param_seq_det_if.sv
// Bus bundle for param_seq_det: serial stream, pattern configuration and detection status.
interface param_seq_det_if #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 16
);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  logic               clr;
  logic               in_valid;
  logic               serin;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   pat_len;
  logic               overlap;
  logic               det_out;
  logic [LEN_W-1:0]   fill;
  logic               len_err;
  logic [CNT_W-1:0]   match_cnt;

  modport master (
    output clr, in_valid, serin, pattern, pat_len, overlap,
    input  det_out, fill, len_err, match_cnt
  );

  modport slave (
    input  clr, in_valid, serin, pattern, pat_len, overlap,
    output det_out, fill, len_err, match_cnt
  );
endinterface

// File: rtl/param_seq_det.sv
// Serial sequence detector with runtime pattern/length and overlap selection.
// Optional saturating detection counter enabled by defining SEQ_DET_CNT_EN.
module param_seq_det #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic           clk,
  input  logic           rst,
  param_seq_det_if.slave bus
);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_det;
  logic               r_len_err;

  logic [MAX_LEN-1:0] w_hist_n;
  logic [MAX_LEN-1:0] w_mask;
  logic [LEN_W-1:0]   w_fill_n;
  logic               w_len_ok;
  logic               w_match;

  // Next history/fill and match against the low pat_len bits only.
  always_comb begin
    w_len_ok = (bus.pat_len != '0) && (32'(bus.pat_len) <= MAX_LEN);
    w_hist_n = {r_hist[MAX_LEN-2:0], bus.serin};
    w_fill_n = (32'(r_fill) >= MAX_LEN) ? r_fill : r_fill + LEN_W'(1);
    w_mask   = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < 32'(bus.pat_len));
    end
    w_match = w_len_ok && (w_fill_n >= bus.pat_len) &&
              (((w_hist_n ^ bus.pattern) & w_mask) == '0);
  end

  // History, fill and detection pulse; clr outranks a valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist <= '0;
      r_fill <= '0;
      r_det  <= 1'b0;
    end else if (bus.clr) begin
      r_fill <= '0;
      r_det  <= 1'b0;
    end else if (bus.in_valid) begin
      r_hist <= w_hist_n;
      r_det  <= w_match;
      r_fill <= (w_match && !bus.overlap) ? '0 : w_fill_n;
    end else begin
      r_det  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_len_err <= 1'b0;
    else     r_len_err <= !w_len_ok;
  end

  assign bus.det_out = r_det;
  assign bus.fill    = r_fill;
  assign bus.len_err = r_len_err;

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  // Saturating count of detections.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (bus.clr) begin
      r_cnt <= '0;
    end else if (bus.in_valid && w_match && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.match_cnt = r_cnt;
`else
  assign bus.match_cnt = '0;
`endif
endmodule

// File: tb/tb_param_seq_det.sv
// Scoreboard bench for param_seq_det: driver queues hand-computed results, monitor checks them.
module tb_param_seq_det;
  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned CNT_W   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  param_seq_det_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

  param_seq_det #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int id;
    int det;
    int fill;
    int lerr;
    int cnt;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_id  = 0;

  logic [MAX_LEN-1:0] p_pat = 8'hF5;
  logic [3:0]         p_len = 4'd3;
  logic               p_ov  = 1'b0;

  // Negative expectation means "don't care" for that field.
  task automatic chk(input int id, input string nm, input int act, input int exp);
    if (exp >= 0) begin
      n_cmp++;
      if (act != exp) begin
        n_bad++;
        $display("FAIL %s step %0d: got %0d expected %0d", nm, id, act, exp);
      end
    end
  endtask

  function automatic int cv(input int n);
`ifdef SEQ_DET_CNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic cfg(input logic [MAX_LEN-1:0] pat, input logic [3:0] len, input logic ov);
    p_pat = pat;
    p_len = len;
    p_ov  = ov;
  endtask

  // One clock of stimulus plus the expected state after the following rising edge.
  task automatic step(input logic c, input logic v, input logic s,
                      input int d, input int f, input int l, input int k);
    @(negedge clk);
    bus.clr      = c;
    bus.in_valid = v;
    bus.serin    = s;
    bus.pattern  = p_pat;
    bus.pat_len  = p_len;
    bus.overlap  = p_ov;
    sb.push_back('{n_id, d, f, l, k});
    n_id++;
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      m_e = sb.pop_front();
      chk(m_e.id, "det_out",   int'(bus.det_out),   m_e.det);
      chk(m_e.id, "fill",      int'(bus.fill),      m_e.fill);
      chk(m_e.id, "len_err",   int'(bus.len_err),   m_e.lerr);
      chk(m_e.id, "match_cnt", int'(bus.match_cnt), m_e.cnt);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bus.clr      = 1'b0;
    bus.in_valid = 1'b0;
    bus.serin    = 1'b0;
    bus.pattern  = p_pat;
    bus.pat_len  = p_len;
    bus.overlap  = p_ov;

    repeat (2) @(negedge clk);
    chk(-1, "rst_det",  int'(bus.det_out),   0);
    chk(-1, "rst_fill", int'(bus.fill),      0);
    chk(-1, "rst_lerr", int'(bus.len_err),   0);
    chk(-1, "rst_cnt",  int'(bus.match_cnt), 0);
    rst = 1'b0;

    // Non-overlapping 101 (upper pattern bits set to junk)
    cfg(8'hF5, 4'd3, 1'b0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 1, 0, -1);
    step(0, 1, 0, 0, 2, 0, -1);
    step(0, 1, 1, 1, 0, 0, -1);
    step(0, 1, 0, 0, 1, 0, -1);
    step(0, 1, 1, 0, 2, 0, -1);

    // Overlapping 101
    cfg(8'hF5, 4'd3, 1'b1);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 1, 0, -1);
    step(0, 1, 0, 0, 2, 0, -1);
    step(0, 1, 1, 1, 3, 0, -1);
    step(0, 1, 0, 0, 4, 0, -1);
    step(0, 1, 1, 1, 5, 0, -1);

    // Asynchronous reset mid-stream while det_out=1 and fill=5
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk(-2, "async_rst_det",  int'(bus.det_out), 0);
    chk(-2, "async_rst_fill", int'(bus.fill),    0);
    chk(-2, "async_rst_lerr", int'(bus.len_err), 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(0, 1, 0, 0, 1, 0, -1);
    step(0, 1, 1, 0, 2, 0, -1);
    step(0, 1, 1, 0, 3, 0, -1);

    // Full length A5 with a two-cycle gap, then saturation of fill
    cfg(8'hA5, 4'd8, 1'b1);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 1, 0, -1);
    step(0, 1, 0, 0, 2, 0, -1);
    step(0, 1, 1, 0, 3, 0, -1);
    step(0, 1, 0, 0, 4, 0, -1);
    step(0, 0, 1, 0, 4, 0, -1);
    step(0, 0, 1, 0, 4, 0, -1);
    step(0, 1, 0, 0, 5, 0, -1);
    step(0, 1, 1, 0, 6, 0, -1);
    step(0, 1, 0, 0, 7, 0, -1);
    step(0, 1, 1, 1, 8, 0, -1);
    step(0, 1, 0, 0, 8, 0, -1);

    // Illegal lengths 0 and 9: len_err and no detections
    cfg(8'hFF, 4'd0, 1'b1);
    step(0, 0, 0, 0, 8, 1, -1);
    step(0, 1, 1, 0, 8, 1, -1);
    step(0, 1, 1, 0, 8, 1, -1);
    step(0, 1, 1, 0, 8, 1, -1);
    cfg(8'hFF, 4'd9, 1'b1);
    step(0, 1, 1, 0, 8, 1, -1);
    step(0, 1, 1, 0, 8, 1, -1);

    // clr beats in_valid; then two 1s give one non-overlapping pulse
    cfg(8'h03, 4'd2, 1'b0);
    step(1, 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 1, 0, -1);
    step(0, 1, 1, 1, 0, 0, -1);

    // Counter: five overlapping detections of 11, then clr
    cfg(8'h03, 4'd2, 1'b1);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 1, 0, cv(0));
    step(0, 1, 1, 1, 2, 0, cv(1));
    step(0, 1, 1, 1, 3, 0, cv(2));
    step(0, 1, 1, 1, 4, 0, cv(3));
    step(0, 1, 1, 1, 5, 0, cv(3));
    step(0, 1, 1, 1, 6, 0, cv(3));
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
